ic74161: RTL and testbench
==========================

// Module: ic74161
// PURPOSE
// - Behavioural model of the 74161 synchronous 4-bit binary counter: asynchronous clear,
//   synchronous parallel load, two count enables and a ripple-carry terminal count.
// - Sits upstream of the quad-NOR/NAND gate models in the lab TTL library.
//   Its Q outputs and TC drive gate models for decode and divide-by-N exercises.
// - Top-level ports are named by DIP pin number. GND/VCC (pins 8, 16) are not modelled.
// PARAMETERS
// - None at top level; the chip is fixed at 4 bits.
// - Sub-module counter_core: WIDTH, default 4, counter width in bits.
// PORTS
// pin_2   input   1  CP: the single clock, rising-edge active
// pin_1   input   1  MR_n: reset, asynchronous, active-low; clears the counter
// pin_3   input   1  D0 parallel data (LSB)
// pin_4   input   1  D1 parallel data
// pin_5   input   1  D2 parallel data
// pin_6   input   1  D3 parallel data (MSB)
// pin_7   input   1  CEP count enable, parallel
// pin_9   input   1  PE_n parallel load, active-low, synchronous
// pin_10  input   1  CET count enable, trickle; also gates TC
// pin_14  output  1  Q0 (LSB)
// pin_13  output  1  Q1
// pin_12  output  1  Q2
// pin_11  output  1  Q3 (MSB)
// pin_15  output  1  TC terminal count
// BEHAVIOUR
// - Reset: pin_1=0 forces Q=4'h0 immediately, independent of clock. TC=0 while in reset.
//   Clock edges are ignored while pin_1=0.
// - The first rising pin_2 with pin_1=1 acts normally; there are no release-delay cycles.
// - Rising pin_2, priority order:
//   1) pin_9=0: Q <= {pin_6,pin_5,pin_4,pin_3}. Load ignores CEP/CET.
//   2) pin_9=1, CEP=1, CET=1: Q <= Q+1 mod 16. 4'hF wraps to 4'h0 with no sticky flag.
//   3) otherwise: Q holds.
// - Latency: Q updates on the same edge that samples the controls. One cycle from controls to Q.
// - TC = CET & (Q==4'hF). Purely combinational, so it is visible in the cycle Q reaches F.
//   TC is independent of CEP and PE_n.
// - Cascade rule: stage N+1 CET is driven by stage N TC; all stages share CEP and pin_2.
//   An 8-bit chain therefore increments its high nibble on the edge where the low nibble goes F->0.
// - Load of 4'hF with CET=1 asserts TC on the same edge that loads it.
// - Async clear asserted mid-cycle (between edges) zeroes Q and TC at once.
//   A clock edge coincident with clear asserting is lost.
// - Inputs are 2-state in normal use. X on a control input must propagate X to Q (no masking).
// STRUCTURE
// - Package ttl_pkg holds shared TTL-library definitions:
//   - typedef logic [3:0] nibble_t
//   - localparam nibble_t NIBBLE_MAX = 4'hF
// - Sub-module counter_core #(WIDTH):
//   - ports: clk, rst_n, load_n, en_p, en_t, d[WIDTH-1:0], q[WIDTH-1:0], tc
//   - contains the async-clear register, next-state mux and TC compare.
// - ic74161 maps DIP pins onto counter_core only (bit order D3..D0, Q3..Q0). It has no logic of its own.
// TESTING
// - Reset: pin_1=0 with random inputs, then pin_1=1 -> Q=0, TC=0 before any clock edge.
// - Count: PE_n=1, CEP=CET=1, 17 edges from 0 -> Q walks 1..F,0,1.
//   TC=1 only while Q=F. No glitch at the wrap.
// - Load: D=4'hC, PE_n=0, CEP=0, one edge -> Q=C.
//   Then PE_n=1, CEP=CET=1, 3 edges -> Q=F with TC=1; one more edge -> Q=0.
// - Enables at Q=F:
//   - CEP=0, CET=1 -> Q holds F, TC=1.
//   - CEP=1, CET=0 -> Q holds F, TC=0.
// - Async clear mid-count: at Q=7, pulse pin_1 low between edges -> Q=0 and TC=0 immediately.
//   The next edge with enables high -> Q=1.
// - Cascade: two instances, low TC -> high CET, preload low=E high=0, 2 edges
//   -> {high,low} = 8'h0F then 8'h10.
//   The high TC asserts only at 8'hFF.

Source files
------------

// File: rtl/ttl_pkg.sv
// Shared definitions for the lab TTL library models.
// Provides the nibble type and the nibble terminal value.
package ttl_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t NIBBLE_MAX = 4'hF;

endpackage

// File: rtl/ic74161_counter_core.sv
// Generic synchronous binary counter with async clear, sync load,
// dual count enables and a combinational terminal count.
// Ports: clk, rst_n (async, active-low), load_n (sync, active-low),
//        en_p/en_t (count enables), d (load data), q (count), tc.
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic             en_p,
    input  logic             en_t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic             cnt_en;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_nxt;

    assign cnt_en = en_p & en_t;
    assign q_inc  = q + 1'b1;

    // Ternaries rather than a case decoder so an X control
    // merges the candidate values and shows up as X on q.
    assign q_nxt = load_n ? (cnt_en ? q_inc : q) : d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

    // Combinational, so it rises in the same cycle q reaches
    // all-ones; en_t gating lets stages ripple-cascade.
    assign tc = en_t & (q == {WIDTH{1'b1}});

endmodule

// File: rtl/ic74161.sv
// 74161 4-bit synchronous binary counter, ports named by DIP pin.
// pin_2 CP, pin_1 MR_n, pin_3..6 D0..D3, pin_7 CEP, pin_9 PE_n,
// pin_10 CET, pin_14..11 Q0..Q3, pin_15 TC.
module ic74161
    import ttl_pkg::*;
(
    input  logic pin_1,
    input  logic pin_2,
    input  logic pin_3,
    input  logic pin_4,
    input  logic pin_5,
    input  logic pin_6,
    input  logic pin_7,
    input  logic pin_9,
    input  logic pin_10,
    output logic pin_11,
    output logic pin_12,
    output logic pin_13,
    output logic pin_14,
    output logic pin_15
);

    nibble_t d;
    nibble_t q;

    assign d = {pin_6, pin_5, pin_4, pin_3};

    counter_core #(
        .WIDTH (4)
    ) u_core (
        .clk    (pin_2),
        .rst_n  (pin_1),
        .load_n (pin_9),
        .en_p   (pin_7),
        .en_t   (pin_10),
        .d      (d),
        .q      (q),
        .tc     (pin_15)
    );

    assign {pin_11, pin_12, pin_13, pin_14} = q;

endmodule

// File: tb/tb_ic74161.sv
// Scoreboard bench for ic74161: single chip plus a two-chip cascade,
// both checked against arithmetic reference models.
module tb_ic74161;
    import ttl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d;
    logic       pe_n, cep, cet;
    logic       q0, q1, q2, q3, tc;

    logic [3:0] cd_lo, cd_hi;
    logic       c_pe_n, c_cep, c_cet;
    logic [3:0] lq, hq;
    logic       ltc, htc;

    always #10 clk = ~clk;

    ic74161 dut (
        .pin_1 (rst_n), .pin_2 (clk),
        .pin_3 (d[0]),  .pin_4 (d[1]),
        .pin_5 (d[2]),  .pin_6 (d[3]),
        .pin_7 (cep),   .pin_9 (pe_n),
        .pin_10(cet),
        .pin_11(q3),    .pin_12(q2),
        .pin_13(q1),    .pin_14(q0),
        .pin_15(tc)
    );

    ic74161 u_lo (
        .pin_1 (rst_n), .pin_2 (clk),
        .pin_3 (cd_lo[0]), .pin_4 (cd_lo[1]),
        .pin_5 (cd_lo[2]), .pin_6 (cd_lo[3]),
        .pin_7 (c_cep), .pin_9 (c_pe_n),
        .pin_10(c_cet),
        .pin_11(lq[3]), .pin_12(lq[2]),
        .pin_13(lq[1]), .pin_14(lq[0]),
        .pin_15(ltc)
    );

    ic74161 u_hi (
        .pin_1 (rst_n), .pin_2 (clk),
        .pin_3 (cd_hi[0]), .pin_4 (cd_hi[1]),
        .pin_5 (cd_hi[2]), .pin_6 (cd_hi[3]),
        .pin_7 (c_cep), .pin_9 (c_pe_n),
        .pin_10(ltc),
        .pin_11(hq[3]), .pin_12(hq[2]),
        .pin_13(hq[1]), .pin_14(hq[0]),
        .pin_15(htc)
    );

    typedef struct {
        bit    casc;
        int    q;
        bit    tc;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mq = 0;
    int   cv = 0;
    event mon_ev;

    task automatic push(input bit casc, input string tag);
        exp_t e;
        e.casc = casc;
        e.tag  = tag;
        if (!casc) begin
            e.q  = mq;
            e.tc = (cet === 1'b1) && (mq == int'(NIBBLE_MAX));
        end else begin
            e.q  = cv;
            e.tc = (c_cet === 1'b1) && (cv == 255);
        end
        sb.push_back(e);
    endtask

    // Reference models: 4-bit and 8-bit counters as plain integers.
    task automatic tick(input string tag, input bit casc = 1'b0);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq = 0;
            cv = 0;
        end else begin
            if (!pe_n)
                mq = int'(d);
            else if (cep && cet)
                mq = (mq + 1) % 16;
            if (!c_pe_n)
                cv = int'({cd_hi, cd_lo});
            else if (c_cep && c_cet)
                cv = (cv + 1) % 256;
        end
        push(casc, tag);
        @(negedge clk);
        #2;
    endtask

    task automatic check_now(input string tag, input bit casc = 1'b0);
        #1;
        push(casc, tag);
        -> mon_ev;
        #1;
    endtask

    task automatic clear_pulse();
        rst_n = 1'b0;
        mq = 0;
        cv = 0;
        check_now("async_clear");
        rst_n = 1'b1;
        check_now("clear_release");
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        logic [7:0] want;
        logic       gtc;
        forever begin
            @(negedge clk or mon_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                want = e.q[7:0];
                if (e.casc) begin
                    got = {hq, lq};
                    gtc = htc;
                end else begin
                    got = {4'h0, q3, q2, q1, q0};
                    gtc = tc;
                end
                checks++;
                if (got !== want || gtc !== e.tc) begin
                    errors++;
                    $display("FAIL %s: got q=%h tc=%b, expected q=%h tc=%b",
                             e.tag, got, gtc, want, e.tc);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n  = 1'b0;
        d      = 4'($urandom_range(0, 15));
        pe_n   = 1'($urandom_range(0, 1));
        cep    = 1'($urandom_range(0, 1));
        cet    = 1'($urandom_range(0, 1));
        cd_lo  = 4'h0;
        cd_hi  = 4'h0;
        c_pe_n = 1'b1;
        c_cep  = 1'b0;
        c_cet  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick("reset_hold");
            d    = 4'($urandom_range(0, 15));
            pe_n = 1'($urandom_range(0, 1));
            cep  = 1'($urandom_range(0, 1));
            cet  = 1'($urandom_range(0, 1));
        end
        rst_n = 1'b1;
        check_now("reset_release");

        pe_n = 1'b1; cep = 1'b1; cet = 1'b1;
        for (int i = 0; i < 17; i++)
            tick("count_walk");

        d = 4'hC; pe_n = 1'b0; cep = 1'b0; cet = 1'b1;
        tick("load_c");
        pe_n = 1'b1; cep = 1'b1; cet = 1'b1;
        for (int i = 0; i < 3; i++)
            tick("count_to_f");
        tick("wrap_to_0");

        d = 4'hF; pe_n = 1'b0; cep = 1'b0; cet = 1'b1;
        tick("load_f_tc");
        pe_n = 1'b1; cep = 1'b0; cet = 1'b1;
        tick("hold_cep0");
        cep = 1'b1; cet = 1'b0;
        check_now("tc_gated_by_cet");
        tick("hold_cet0");

        d = 4'h7; pe_n = 1'b0;
        tick("load_7");
        pe_n = 1'b1; cep = 1'b1; cet = 1'b1;
        clear_pulse();
        tick("after_clear");

        for (int i = 0; i < 150; i++) begin
            d    = 4'($urandom_range(0, 15));
            pe_n = ($urandom_range(0, 3) != 0);
            cep  = ($urandom_range(0, 4) != 0);
            cet  = ($urandom_range(0, 4) != 0);
            tick("random");
            if ($urandom_range(0, 24) == 0)
                clear_pulse();
        end

        pe_n = 1'b1; cep = 1'b0; cet = 1'b0;
        cd_lo = 4'hE; cd_hi = 4'h0;
        c_pe_n = 1'b0; c_cep = 1'b1; c_cet = 1'b1;
        tick("casc_load", 1'b1);
        c_pe_n = 1'b1;
        tick("casc_0f", 1'b1);
        tick("casc_10", 1'b1);

        cd_lo = 4'hD; cd_hi = 4'hF; c_pe_n = 1'b0;
        tick("casc_load_fd", 1'b1);
        c_pe_n = 1'b1;
        for (int i = 0; i < 3; i++)
            tick("casc_ff_wrap", 1'b1);

        for (int i = 0; i < 60; i++) begin
            cd_lo  = 4'($urandom_range(0, 15));
            cd_hi  = 4'($urandom_range(0, 15));
            c_pe_n = ($urandom_range(0, 9) != 0);
            c_cep  = ($urandom_range(0, 4) != 0);
            c_cet  = ($urandom_range(0, 4) != 0);
            tick("casc_random", 1'b1);
        end

        @(negedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
